// File: rtl/dmem_loader_pkg.sv
// Shared types and derived sizing for the data-memory loader.
// Defaults describe a 3x4 by 4x1 matrix product image.
package dmem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WRITE  = 3'd2,
        CLEAR  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int DEF_M  = 3;
    localparam int DEF_N  = 4;
    localparam int DEF_N2 = 1;

    function automatic int calc_total_words(input int m, input int n, input int n2);
        return (m * n) + (n * n2);
    endfunction

    function automatic int calc_result_base(input int m, input int n, input int n2);
        return calc_total_words(m, n, n2) * 4;
    endfunction

    function automatic int calc_result_bytes(input int m, input int n2);
        return m * n2 * 4;
    endfunction

    localparam int TOTAL_WORDS  = calc_total_words(DEF_M, DEF_N, DEF_N2);
    localparam int RESULT_BASE  = calc_result_base(DEF_M, DEF_N, DEF_N2);
    localparam int RESULT_BYTES = calc_result_bytes(DEF_M, DEF_N2);

endpackage

// File: rtl/word_serializer.sv
// Holds one accepted 32-bit word and presents its bytes most-significant first,
// advancing a 2-bit byte index on each step.
module word_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        step,
    output logic [7:0]  byte_data,
    output logic        last_byte
);

    logic [31:0] word_r;
    logic [1:0]  idx_r;

    // Capture the word on load and walk the byte index while stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= 32'd0;
            idx_r  <= 2'd0;
        end else if (load) begin
            word_r <= word;
            idx_r  <= 2'd0;
        end else if (step) begin
            idx_r  <= idx_r + 2'd1;
        end else begin
            word_r <= word_r;
            idx_r  <= idx_r;
        end
    end

    // Big-endian byte select
    always_comb begin
        byte_data = 8'h00;
        case (idx_r)
            2'd0:    byte_data = word_r[31:24];
            2'd1:    byte_data = word_r[23:16];
            2'd2:    byte_data = word_r[15:8];
            2'd3:    byte_data = word_r[7:0];
            default: byte_data = 8'h00;
        endcase
    end

    assign last_byte = (idx_r == 2'd3);

endmodule

// File: rtl/dmem_loader.sv
// Streams matrix words into CPU data memory as bytes, zeroes the result area,
// then releases the CPU from reset.
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int M      = DEF_M,
    parameter int N      = DEF_N,
    parameter int N2     = DEF_N2,
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [15:0]       word_cnt
);

    localparam int CFG_TOTAL_WORDS  = calc_total_words(M, N, N2);
    localparam int CFG_RESULT_BASE  = calc_result_base(M, N, N2);
    localparam int CFG_RESULT_BYTES = calc_result_bytes(M, N2);

    localparam logic [15:0]     CNT_MAX = 16'(CFG_TOTAL_WORDS);
    // One extra pointer bit so the end-of-clear address never wraps to zero
    localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(CFG_RESULT_BASE + CFG_RESULT_BYTES);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    state_e            state_r;
    logic [ADDR_W:0]   ptr_r;
    logic [15:0]       word_cnt_r;
    logic              in_ready_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic              cpu_hold_r;
    logic              load_done_r;

    logic              ser_load_s;
    logic              ser_step_s;
    logic [7:0]        ser_byte_s;
    logic              ser_last_s;

    assign ser_load_s = (state_r == ACCEPT) && in_valid;
    assign ser_step_s = (state_r == WRITE);

    word_serializer u_ser (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .load      (ser_load_s),
        .word      (in_data),
        .step      (ser_step_s),
        .byte_data (ser_byte_s),
        .last_byte (ser_last_s)
    );

    // Sequencer: accept a word, emit its four bytes, then zero the result area
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            word_cnt_r  <= 16'd0;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 8'h00;
            cpu_hold_r  <= 1'b1;
            load_done_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mem_we_r <= 1'b0;
                    if (start) begin
                        state_r    <= ACCEPT;
                        in_ready_r <= 1'b1;
                        word_cnt_r <= 16'd0;
                        ptr_r      <= '0;
                    end
                end
                ACCEPT: begin
                    mem_we_r <= 1'b0;
                    if (in_valid) begin
                        state_r    <= WRITE;
                        in_ready_r <= 1'b0;
                        if (word_cnt_r < CNT_MAX) begin
                            word_cnt_r <= word_cnt_r + 16'd1;
                        end
                    end
                end
                WRITE: begin
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= ptr_r[ADDR_W-1:0];
                    mem_wdata_r <= ser_byte_s;
                    ptr_r       <= ptr_r + PTR_ONE;
                    if (ser_last_s) begin
                        if (word_cnt_r < CNT_MAX) begin
                            state_r    <= ACCEPT;
                            in_ready_r <= 1'b1;
                        end else begin
                            state_r    <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    if (ptr_r < CLR_END) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= ptr_r[ADDR_W-1:0];
                        mem_wdata_r <= 8'h00;
                        ptr_r       <= ptr_r + PTR_ONE;
                    end else begin
                        mem_we_r    <= 1'b0;
                        state_r     <= DONE;
                        cpu_hold_r  <= 1'b0;
                        load_done_r <= 1'b1;
                    end
                end
                DONE: begin
                    mem_we_r <= 1'b0;
                    if (start) begin
                        state_r     <= ACCEPT;
                        in_ready_r  <= 1'b1;
                        cpu_hold_r  <= 1'b1;
                        load_done_r <= 1'b0;
                        word_cnt_r  <= 16'd0;
                        ptr_r       <= '0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    mem_we_r    <= 1'b0;
                    cpu_hold_r  <= 1'b1;
                    load_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_hold  = cpu_hold_r;
    assign load_done = load_done_r;
    assign word_cnt  = word_cnt_r;

endmodule

// File: doc/dmem_loader.md
DMEM_LOADER -- requirements
Module: dmem_loader

Interface
REQ-001 Parameter M, default 3: rows of matrix1.
REQ-002 Parameter N, default 4: columns of matrix1 and rows of matrix2.
REQ-003 Parameter N2, default 1: columns of matrix2.
REQ-004 Parameter ADDR_W, default 8: data-memory byte-address width, at least clog2((M*N+N*N2+M*N2)*4).
REQ-005 CLOCK_50  input  1  sole clock, rising-edge.
REQ-006 RESET_N  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle request to begin a load sequence.
REQ-008 in_valid  input  1  in_data holds a valid word.
REQ-009 in_data  input  32  signed matrix word, matrix1 row-major first, then matrix2 row-major.
REQ-010 in_ready  output  1  loader accepts in_data this cycle.
REQ-011 mem_we  output  1  byte write strobe to CPU data memory.
REQ-012 mem_addr  output  ADDR_W  byte address of the write.
REQ-013 mem_wdata  output  8  byte written.
REQ-014 cpu_hold  output  1  holds the CPU in reset while high.
REQ-015 load_done  output  1  level, high once the load and clear have completed.
REQ-016 word_cnt  output  16  count of words accepted in the current sequence.

Function
REQ-017 The FSM SHALL use states IDLE, ACCEPT, WRITE, CLEAR and DONE.
REQ-018 IDLE SHALL go to ACCEPT on start=1 and clear word_cnt and the address pointer.
REQ-019 In ACCEPT, in_ready SHALL be 1; an in_valid&in_ready cycle SHALL latch in_data, increment word_cnt and go to WRITE.
REQ-020 WRITE SHALL spend exactly 4 cycles with mem_we=1, writing in_data[31:24],[23:16],[15:8],[7:0] to byte addresses 4k, 4k+1, 4k+2, 4k+3 for word k (big-endian).
REQ-021 Latency: a word accepted at edge t SHALL produce its byte writes on the cycles following edges t+1..t+4; peak throughput is one word per 5 cycles.
REQ-022 After the 4th byte, WRITE SHALL return to ACCEPT if word_cnt < M*N+N*N2, else go to CLEAR.
REQ-023 CLEAR SHALL write 0x00 to each byte from RESULT_BASE=(M*N+N*N2)*4 through RESULT_BASE+M*N2*4-1, one byte per cycle, then go to DONE.
REQ-024 In DONE, cpu_hold SHALL be 0 and load_done SHALL be 1; both SHALL hold until the next start.
REQ-025 start in DONE SHALL re-enter ACCEPT, with cpu_hold=1 and load_done=0 on the next cycle.
REQ-026 start in ACCEPT, WRITE or CLEAR SHALL be ignored.
REQ-027 in_ready SHALL be 0 in every state except ACCEPT; words offered outside ACCEPT SHALL be neither accepted nor counted.
REQ-028 mem_we SHALL be 0 outside WRITE and CLEAR; mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-029 cpu_hold SHALL be 1 in every state except DONE.
REQ-030 word_cnt SHALL saturate at M*N+N*N2 and never wrap.

Reset
REQ-031 When RESET_N=0, all state SHALL clear asynchronously: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, word_cnt=0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence with no further writes; a fresh start SHALL be required after release.

Structure
REQ-033 Package dmem_loader_pkg SHALL hold the state enumeration and derived constants TOTAL_WORDS, RESULT_BASE and RESULT_BYTES.
REQ-034 Sub-module word_serializer SHALL perform the 32-to-8 big-endian byte serialization with a 2-bit byte index; the FSM, counters and CLEAR address generation stay in dmem_loader.

Verification
REQ-035 Default parameters, start, then 16 words 1..16 streamed continuously -> 76 writes total, addr 0..63 carrying the big-endian bytes, then zeros at 64..75; load_done=1 and cpu_hold=0 the cycle after byte 75.
REQ-036 in_data=0xDEADBEEF as word 0 -> mem 0..3 = DE, AD, BE, EF in that order on consecutive cycles.
REQ-037 in_valid held 1 continuously -> in_ready pulses once per 5 cycles; exactly 16 accepts; word_cnt=16 in DONE.
REQ-038 RESET_N pulsed low after 7 accepted words -> mem_we=0 immediately, cpu_hold=1, word_cnt=0; after start plus 16 words, the normal completion of REQ-035 follows.
REQ-039 start pulsed in WRITE, and in_valid=1 during CLEAR -> no change in sequence, no extra accepts or writes.
REQ-040 Negative word -7 (0xFFFFFFF9) loaded -> bytes FF, FF, FF, F9; second start from DONE reloads successfully.
